// File: rtl/worker_pool_arbiter.sv
// worker_pool_arbiter: shares NUM_WORKERS workers between one packet
// stream (PC_*) and one merged, registered result stream (WR_*).
// Ports:
//   CLK, RST_N            clock, async active-low reset
//   PC_VALID/READY/DATA   upstream packets, one-entry buffered
//   W_PC_VALID/READY/DATA round-robin dispatch (one-hot valid, data broadcast)
//   W_WR_VALID/READY/DATA per-worker results (worker i at [i*W +: W])
//   WR_VALID/READY/DATA   merged registered result
//   DISPATCH_COUNT        packets dispatched (wrapping)
//   RESULT_COUNT          results delivered downstream (wrapping)
module worker_pool_arbiter #(
    parameter int NUM_WORKERS         = 4,
    parameter int PACKET_WIDTH        = 64,
    parameter int WORKER_RESULT_WIDTH = 67,
    parameter int PTR_W               = 3
) (
    input  logic                                       CLK,
    input  logic                                       RST_N,
    input  logic                                       PC_VALID,
    output logic                                       PC_READY,
    input  logic [PACKET_WIDTH-1:0]                    PC_DATA,
    output logic [NUM_WORKERS-1:0]                     W_PC_VALID,
    input  logic [NUM_WORKERS-1:0]                     W_PC_READY,
    output logic [PACKET_WIDTH-1:0]                    W_PC_DATA,
    input  logic [NUM_WORKERS-1:0]                     W_WR_VALID,
    output logic [NUM_WORKERS-1:0]                     W_WR_READY,
    input  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] W_WR_DATA,
    output logic                                       WR_VALID,
    input  logic                                       WR_READY,
    output logic [WORKER_RESULT_WIDTH-1:0]             WR_DATA,
    output logic [15:0]                                DISPATCH_COUNT,
    output logic [15:0]                                RESULT_COUNT
);

    localparam int N = NUM_WORKERS;
    localparam int W = WORKER_RESULT_WIDTH;

    // Picks the requesting index closest to ptr going upward, modulo N.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [N-1:0]     req,
        input logic [PTR_W-1:0] ptr
    );
        logic [PTR_W-1:0] g;
        int               best;
        int               d;
        g    = '0;
        best = N;
        d    = 0;
        for (int j = 0; j < N; j++) begin
            d = (j - int'(ptr) + N) % N;
            if (req[j] && d < best) begin
                best = d;
                g    = PTR_W'(j);
            end
        end
        return g;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_after(
        input logic [PTR_W-1:0] g
    );
        return (g == PTR_W'(N - 1)) ? '0 : g + PTR_W'(1);
    endfunction

    logic                    buf_valid;
    logic [PACKET_WIDTH-1:0] buf_data;
    logic [PTR_W-1:0]        dptr;
    logic [PTR_W-1:0]        rptr;

    logic                    dany;
    logic [PTR_W-1:0]        dgrant;
    logic                    dispatch_fire;
    logic                    load;

    logic                    rany;
    logic [PTR_W-1:0]        rgrant;
    logic                    out_free;
    logic                    r_accept;
    logic                    deliver;
    logic [W-1:0]            rdata;

    assign dany          = |W_PC_READY;
    assign dgrant        = rr_pick(W_PC_READY, dptr);
    assign dispatch_fire = RST_N && buf_valid && dany;
    assign PC_READY      = RST_N && (!buf_valid || dispatch_fire);
    assign load          = PC_VALID && PC_READY;
    assign W_PC_DATA     = buf_data;

    assign rany     = |W_WR_VALID;
    assign rgrant   = rr_pick(W_WR_VALID, rptr);
    assign out_free = !WR_VALID || WR_READY;
    assign r_accept = RST_N && rany && out_free;
    assign deliver  = WR_VALID && WR_READY;

    // One-hot strobes and result mux use constant indices only.
    always_comb begin
        W_PC_VALID = '0;
        W_WR_READY = '0;
        rdata      = '0;
        for (int j = 0; j < N; j++) begin
            W_PC_VALID[j] = dispatch_fire && (dgrant == PTR_W'(j));
            W_WR_READY[j] = r_accept && (rgrant == PTR_W'(j));
            if (rgrant == PTR_W'(j)) begin
                rdata = W_WR_DATA[j*W +: W];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            buf_valid      <= 1'b0;
            buf_data       <= '0;
            dptr           <= '0;
            DISPATCH_COUNT <= '0;
        end else begin
            if (load) begin
                buf_valid <= 1'b1;
                buf_data  <= PC_DATA;
            end else if (dispatch_fire) begin
                buf_valid <= 1'b0;
            end
            if (dispatch_fire) begin
                dptr           <= ptr_after(dgrant);
                DISPATCH_COUNT <= DISPATCH_COUNT + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WR_VALID     <= 1'b0;
            WR_DATA      <= '0;
            rptr         <= '0;
            RESULT_COUNT <= '0;
        end else begin
            if (r_accept) begin
                WR_VALID <= 1'b1;
                WR_DATA  <= rdata;
                rptr     <= ptr_after(rgrant);
            end else if (deliver) begin
                WR_VALID <= 1'b0;
            end
            if (deliver) begin
                RESULT_COUNT <= RESULT_COUNT + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_worker_pool_arbiter.sv
// tb_worker_pool_arbiter: directed table, hand sequences and random
// traffic checked against a rotation-order reference model.
module tb_worker_pool_arbiter;

    localparam int NW = 4;
    localparam int PW = 64;
    localparam int RW = 67;

    logic           clk;
    logic           rst_n;
    logic           pc_valid;
    logic           pc_ready;
    logic [PW-1:0]  pc_data;
    logic [NW-1:0]  w_pc_valid;
    logic [NW-1:0]  w_pc_ready;
    logic [PW-1:0]  w_pc_data;
    logic [NW-1:0]  w_wr_valid;
    logic [NW-1:0]  w_wr_ready;
    logic [NW*RW-1:0] w_wr_data;
    logic           wr_valid;
    logic           wr_ready;
    logic [RW-1:0]  wr_data;
    logic [15:0]    dispatch_count;
    logic [15:0]    result_count;

    logic [RW-1:0]  res [NW];

    always_comb begin
        w_wr_data = '0;
        for (int i = 0; i < NW; i++) begin
            w_wr_data[i*RW +: RW] = res[i];
        end
    end

    worker_pool_arbiter #(
        .NUM_WORKERS(NW),
        .PACKET_WIDTH(PW),
        .WORKER_RESULT_WIDTH(RW),
        .PTR_W(3)
    ) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .PC_VALID(pc_valid),
        .PC_READY(pc_ready),
        .PC_DATA(pc_data),
        .W_PC_VALID(w_pc_valid),
        .W_PC_READY(w_pc_ready),
        .W_PC_DATA(w_pc_data),
        .W_WR_VALID(w_wr_valid),
        .W_WR_READY(w_wr_ready),
        .W_WR_DATA(w_wr_data),
        .WR_VALID(wr_valid),
        .WR_READY(wr_ready),
        .WR_DATA(wr_data),
        .DISPATCH_COUNT(dispatch_count),
        .RESULT_COUNT(result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model state.
    bit            m_buf_valid;
    logic [PW-1:0] m_buf_data;
    int            m_dptr;
    int            m_rptr;
    bit            m_wr_valid;
    logic [RW-1:0] m_wr_data;
    int            m_dcnt;
    int            m_rcnt;

    task automatic model_reset();
        m_buf_valid = 0;
        m_buf_data  = '0;
        m_dptr      = 0;
        m_rptr      = 0;
        m_wr_valid  = 0;
        m_wr_data   = '0;
        m_dcnt      = 0;
        m_rcnt      = 0;
    endtask

    // First set bit of m visiting p, p+1, ... modulo NW; -1 if none.
    function automatic int first_from(input logic [NW-1:0] m, input int p);
        int idx;
        for (int k = 0; k < NW; k++) begin
            idx = (p + k) % NW;
            if (m[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [RW-1:0] mk_res(input int i);
        logic [31:0] lo;
        lo = 32'hdeadbeef + 32'(i);
        return {3'b110, 16'h00ff, 16'heeee, lo};
    endfunction

    // Compare one cycle against the model, then advance it over the edge.
    task automatic step();
        int  dg;
        int  rg;
        bit  fire;
        bit  ex_pc_ready;
        bit  acc;
        bit  dlv;
        logic [NW-1:0] ex_wpv;
        logic [NW-1:0] ex_wwr;
        dg          = first_from(w_pc_ready, m_dptr);
        fire        = m_buf_valid && dg >= 0;
        ex_pc_ready = !m_buf_valid || fire;
        ex_wpv      = fire ? (NW'(1) << dg) : '0;
        rg          = first_from(w_wr_valid, m_rptr);
        acc         = rg >= 0 && (!m_wr_valid || wr_ready);
        ex_wwr      = acc ? (NW'(1) << rg) : '0;
        dlv         = m_wr_valid && wr_ready;
        chk("pc_ready", 128'(pc_ready), 128'(ex_pc_ready));
        chk("w_pc_valid", 128'(w_pc_valid), 128'(ex_wpv));
        if (m_buf_valid) chk("w_pc_data", 128'(w_pc_data), 128'(m_buf_data));
        chk("w_wr_ready", 128'(w_wr_ready), 128'(ex_wwr));
        chk("wr_valid", 128'(wr_valid), 128'(m_wr_valid));
        chk("wr_data", 128'(wr_data), 128'(m_wr_data));
        chk("dispatch_count", 128'(dispatch_count), 128'(m_dcnt[15:0]));
        chk("result_count", 128'(result_count), 128'(m_rcnt[15:0]));
        @(posedge clk);
        if (fire) begin
            m_dptr = (dg + 1) % NW;
            m_dcnt = (m_dcnt + 1) % 65536;
        end
        if (pc_valid && ex_pc_ready) begin
            m_buf_valid = 1;
            m_buf_data  = pc_data;
        end else if (fire) begin
            m_buf_valid = 0;
        end
        if (dlv) m_rcnt = (m_rcnt + 1) % 65536;
        if (acc) begin
            m_wr_valid = 1;
            m_wr_data  = res[rg[1:0]];
            m_rptr     = (rg + 1) % NW;
        end else if (dlv) begin
            m_wr_valid = 0;
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic          pv;
        logic [PW-1:0] pd;
        logic [NW-1:0] wpr;
        logic          epr;
        logic [NW-1:0] ewpv;
        logic [PW-1:0] ed;
        logic [15:0]   edc;
    } vec_t;

    vec_t tbl [15];
    logic [RW-1:0] held;
    int rc0;

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        tbl[0]  = '{1'b1, 64'd1, 4'hF, 1'b1, 4'h0, 64'd0, 16'd0};
        tbl[1]  = '{1'b1, 64'd2, 4'hF, 1'b1, 4'h1, 64'd1, 16'd0};
        tbl[2]  = '{1'b1, 64'd3, 4'hF, 1'b1, 4'h2, 64'd2, 16'd1};
        tbl[3]  = '{1'b1, 64'd4, 4'hF, 1'b1, 4'h4, 64'd3, 16'd2};
        tbl[4]  = '{1'b0, 64'd0, 4'hF, 1'b1, 4'h8, 64'd4, 16'd3};
        tbl[5]  = '{1'b0, 64'd0, 4'hF, 1'b1, 4'h0, 64'd0, 16'd4};
        tbl[6]  = '{1'b1, 64'd5, 4'hA, 1'b1, 4'h0, 64'd0, 16'd4};
        tbl[7]  = '{1'b1, 64'd6, 4'hA, 1'b1, 4'h2, 64'd5, 16'd4};
        tbl[8]  = '{1'b0, 64'd0, 4'hA, 1'b1, 4'h8, 64'd6, 16'd5};
        tbl[9]  = '{1'b1, 64'd7, 4'h0, 1'b1, 4'h0, 64'd0, 16'd6};
        tbl[10] = '{1'b1, 64'd8, 4'h0, 1'b0, 4'h0, 64'd0, 16'd6};
        tbl[11] = '{1'b1, 64'd8, 4'h0, 1'b0, 4'h0, 64'd0, 16'd6};
        tbl[12] = '{1'b1, 64'd8, 4'h1, 1'b1, 4'h1, 64'd7, 16'd6};
        tbl[13] = '{1'b0, 64'd0, 4'h1, 1'b1, 4'h1, 64'd8, 16'd7};
        tbl[14] = '{1'b0, 64'd0, 4'h0, 1'b1, 4'h0, 64'd0, 16'd8};

        // Reset with every handshake input active.
        rst_n      = 1'b0;
        pc_valid   = 1'b1;
        pc_data    = '1;
        w_pc_ready = 4'hF;
        w_wr_valid = 4'hF;
        wr_ready   = 1'b1;
        for (int i = 0; i < NW; i++) res[i] = mk_res(i);
        #3;
        chk("rst_pc_ready", 128'(pc_ready), 128'(0));
        chk("rst_wr_valid", 128'(wr_valid), 128'(0));
        chk("rst_w_pc_valid", 128'(w_pc_valid), 128'(0));
        chk("rst_w_wr_ready", 128'(w_wr_ready), 128'(0));
        @(negedge clk);
        rst_n      = 1'b1;
        pc_valid   = 1'b0;
        w_wr_valid = '0;
        #1;
        chk("post_rst_pc_ready", 128'(pc_ready), 128'(1));
        chk("post_rst_dcnt", 128'(dispatch_count), 128'(0));
        chk("post_rst_rcnt", 128'(result_count), 128'(0));

        // Dispatch round-robin, busy-skip and starvation table.
        for (int i = 0; i < 15; i++) begin
            pc_valid   = tbl[i].pv;
            pc_data    = tbl[i].pd;
            w_pc_ready = tbl[i].wpr;
            #1;
            chk($sformatf("tbl%0d_pc_ready", i), 128'(pc_ready),
                128'(tbl[i].epr));
            chk($sformatf("tbl%0d_w_pc_valid", i), 128'(w_pc_valid),
                128'(tbl[i].ewpv));
            if (tbl[i].ewpv != 0)
                chk($sformatf("tbl%0d_w_pc_data", i), 128'(w_pc_data),
                    128'(tbl[i].ed));
            chk($sformatf("tbl%0d_dcnt", i), 128'(dispatch_count),
                128'(tbl[i].edc));
            step();
        end

        // Result merge: all four valid together.
        pc_valid   = 1'b0;
        w_pc_ready = '0;
        w_wr_valid = 4'hF;
        wr_ready   = 1'b1;
        for (int r = 0; r < 5; r++) begin
            #1;
            chk($sformatf("merge%0d_w_wr_ready", r), 128'(w_wr_ready),
                128'((r < 4) ? (4'b1 << r) : 4'b0));
            if (r > 0) begin
                chk($sformatf("merge%0d_wr_valid", r), 128'(wr_valid),
                    128'(1));
                chk($sformatf("merge%0d_wr_data", r), 128'(wr_data),
                    128'(mk_res(r - 1)));
            end
            step();
            if (r < 4) w_wr_valid[r] = 1'b0;
        end

        // Backpressure: hold result from worker 1 for 5 cycles.
        w_wr_valid = 4'b0110;
        wr_ready   = 1'b0;
        #1;
        step();
        w_wr_valid = 4'b0100;
        held = mk_res(1);
        rc0  = m_rcnt;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_wr_data", 128'(wr_data), 128'(held));
            chk("bp_w_wr_ready", 128'(w_wr_ready), 128'(0));
            chk("bp_rcnt", 128'(result_count), 128'(rc0));
            step();
        end
        wr_ready = 1'b1;
        #1;
        chk("bp_release_grant", 128'(w_wr_ready), 128'(4'b0100));
        step();
        w_wr_valid = '0;
        chk("bp_release_rcnt", 128'(result_count), 128'(rc0 + 1));
        chk("bp_release_data", 128'(wr_data), 128'(mk_res(2)));

        // Reset mid-stream with a buffered packet and a held result.
        wr_ready = 1'b0;
        pc_valid = 1'b1;
        pc_data  = 64'hcafe;
        #1;
        step();
        pc_valid = 1'b0;
        #1;
        chk("mid_pre_pc_ready", 128'(pc_ready), 128'(0));
        chk("mid_pre_wr_valid", 128'(wr_valid), 128'(1));
        #2;
        rst_n      = 1'b0;
        w_pc_ready = 4'hF;
        w_wr_valid = 4'hF;
        #1;
        chk("mid_rst_wr_valid", 128'(wr_valid), 128'(0));
        chk("mid_rst_wr_data", 128'(wr_data), 128'(0));
        chk("mid_rst_pc_ready", 128'(pc_ready), 128'(0));
        chk("mid_rst_w_pc_valid", 128'(w_pc_valid), 128'(0));
        chk("mid_rst_w_wr_ready", 128'(w_wr_ready), 128'(0));
        model_reset();
        @(negedge clk);
        rst_n      = 1'b1;
        w_wr_valid = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("mid_after_w_pc_valid", 128'(w_pc_valid), 128'(0));
            step();
        end

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            pc_valid   = 1'($urandom);
            pc_data    = {$urandom, $urandom};
            w_pc_ready = NW'($urandom);
            w_wr_valid = NW'($urandom);
            wr_ready   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NW; i++)
                res[i] = {3'($urandom), $urandom, $urandom};
            #1;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/worker_pool_arbiter.md
# worker_pool_arbiter

Shares a pool of `worker` instances between one packet stream and one result stream. Packets arriving on the PC handshake are buffered and dispatched round-robin to the next worker that is ready. Results from all workers are merged round-robin into a single registered WR output. The block sits between the packet matcher and the result router, in place of a single worker.

## Interface
- `NUM_WORKERS`, default 4: number of attached workers; legal range 2..8.
- `PACKET_WIDTH`, `WORKER_RESULT_WIDTH`: taken from `include/param.vh`; not overridden.
- `PTR_W`, default 3: width of the round-robin pointers; must satisfy 2^PTR_W >= NUM_WORKERS.

Ports:
- `CLK` in 1: single clock; all state is on its rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `PC_VALID` in 1: upstream packet valid.
- `PC_READY` out 1: upstream packet ready.
- `PC_DATA` in PACKET_WIDTH: upstream packet.
- `W_PC_VALID` out NUM_WORKERS: per-worker dispatch valid; one-hot or zero.
- `W_PC_READY` in NUM_WORKERS: per-worker dispatch ready.
- `W_PC_DATA` out PACKET_WIDTH: dispatch packet, broadcast to all workers.
- `W_WR_VALID` in NUM_WORKERS: per-worker result valid.
- `W_WR_READY` out NUM_WORKERS: per-worker result ready; one-hot or zero.
- `W_WR_DATA` in NUM_WORKERS*WORKER_RESULT_WIDTH: results; worker i occupies slice [i*W +: W].
- `WR_VALID` out 1: merged result valid.
- `WR_READY` in 1: downstream ready.
- `WR_DATA` out WORKER_RESULT_WIDTH: merged result.
- `DISPATCH_COUNT` out 16: packets dispatched, wrapping.
- `RESULT_COUNT` out 16: results delivered downstream, wrapping.

## Operation
Dispatch side:
- One-entry input buffer holds `buf_valid` and `buf_data`.
- `PC_READY = RST_N && (!buf_valid || dispatch_fire)`.
- The buffer loads on `PC_VALID && PC_READY`.
- `W_PC_DATA = buf_data`.
- `dgrant` is the first index j, searching from `dptr` upward modulo NUM_WORKERS, with `W_PC_READY[j]` high.
- `W_PC_VALID[dgrant] = buf_valid` when any ready bit is set; otherwise `W_PC_VALID` is all zero.
- `dispatch_fire` is true when any `W_PC_VALID & W_PC_READY` bit is set.
- On `dispatch_fire`: `dptr <= dgrant+1` (wraps to 0 after NUM_WORKERS-1), and `DISPATCH_COUNT` increments.
- If load and fire happen in the same cycle, the buffer is replaced and `buf_valid` stays 1.
- Workers must not make `W_PC_READY` depend on `W_PC_VALID`. This is a contract on the worker, not checked by this block.

Result side:
- Output register holds `WR_VALID` and `WR_DATA`; `out_free = !WR_VALID || WR_READY`.
- `rgrant` is the first index with `W_WR_VALID` set, searching from `rptr`.
- `W_WR_READY[rgrant] = out_free` when any valid bit is set; all other bits are 0.
- On acceptance:
  - `WR_DATA <= slice[rgrant]`, `WR_VALID <= 1`.
  - `rptr <= rgrant+1`, with the same wrap rule as `dptr`.
- If downstream takes the output (`WR_VALID && WR_READY`) and no new result is accepted, `WR_VALID <= 0`.
- `RESULT_COUNT` increments on `WR_VALID && WR_READY`.
- While `WR_VALID && !WR_READY`, `WR_DATA` is held stable and all `W_WR_READY` are 0.
- Multi-result instructions (DISTRIBUTE, SYNC) come out of a worker as consecutive results. Each is arbitrated independently; results from other workers may interleave between them.

## Timing
- Reset (`RST_N` low, asynchronous):
  - `buf_valid`, `WR_VALID`, `dptr`, `rptr` and both counters clear to 0.
  - `WR_DATA` clears to 0.
  - `PC_READY`, `W_PC_VALID` and `W_WR_READY` are forced to 0.
- Reset in mid-operation discards the buffered packet and the held result.
- First cycle after reset: `PC_READY = 1`.
- Dispatch latency: a packet accepted in cycle n is offered to a worker in cycle n+1. Sustained throughput is 1 packet per cycle while some worker is ready.
- All workers busy: the buffer holds, `PC_READY` goes to 0, and `W_PC_VALID` is 0.
- Result latency: a result accepted from a worker in cycle n is on `WR_DATA` in cycle n+1. Throughput is 1 per cycle when `WR_READY` is held high.
- Counters wrap from 16'hffff to 0.

## Test plan
- Reset: hold `RST_N` low for 1 cycle -> `PC_READY`, `WR_VALID` and all `W_*` handshake outputs are 0. After release, `PC_READY` is 1 and both counters read 0.
- Round-robin dispatch: 4 back-to-back PLUS packets, all workers ready -> the packets go to workers 0, 1, 2, 3 in order, one per cycle starting the cycle after the first accept; `DISPATCH_COUNT` reads 4.
- Skip busy worker, then starve:
  - Drive `W_PC_READY = 4'b1010` with `dptr = 0` and send a packet -> it goes to worker 1; the next packet goes to worker 3.
  - Then drive `W_PC_READY = 0` -> `PC_READY` drops after the buffer fills; the buffer holds until a worker becomes ready.
- Result merge, all workers valid together:
  - Worker i presents result {3'b110, 16'h00ff, 16'heeee, 32'hdeadbeef+i}.
  - Hold `WR_READY = 1` -> results emerge in order i = 0, 1, 2, 3 on consecutive cycles.
- Backpressure: `WR_READY` low for 5 cycles with a result pending -> `WR_DATA` is stable, all `W_WR_READY` are 0 and `RESULT_COUNT` is unchanged. On release, the held result delivers and the next one is granted in the same cycle.
- Reset mid-stream: assert `RST_N` low while a packet is buffered and a result is held -> `WR_VALID` and the buffer clear immediately, asynchronously, with no extra `W_PC_VALID` pulse after release.
